// File: rtl/grant_executor.sv
// grant_executor
// Applies the accepted-grant matrix from the iSLIP scheduler to the crossbar.
// For every legal grant it configures the crossbar for the granted
// input->output pair, pulses a one-hot dequeue for the highest occupied class
// of that VOQ, and keeps both ports busy for CELL_LEN cycles. The registered
// idle vectors feed back to the scheduler as its idle inputs.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   i_acc_grant    N*N grant matrix, bit [i*N+j] = input i granted to output j
//   i_priority     N*N*P VOQ occupancy, bit [(i*N+j)*P+p] = class p present
//   o_input_idle   registered, 1 = input free
//   o_output_idle  registered, 1 = output free
//   o_xbar_valid   per output, crossbar carrying a cell
//   o_xbar_sel     per output source input index, field [j*LOGN +: LOGN]
//   o_dequeue      one-cycle one-hot dequeue pulse per VOQ class
//   o_err          sticky protocol-error flag
//
// Build option: define GRANT_CHECK_EN to build the protocol checker that
// drives o_err; otherwise o_err is tied 0 and no checking logic exists.
module grant_executor #(
   parameter int N        = 12,
   parameter int P        = 8,
   parameter int LOGN     = 4,
   parameter int CELL_LEN = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N*N-1:0]      i_acc_grant,
   input  logic [N*N*P-1:0]    i_priority,
   output logic [N-1:0]        o_input_idle,
   output logic [N-1:0]        o_output_idle,
   output logic [N-1:0]        o_xbar_valid,
   output logic [N*LOGN-1:0]   o_xbar_sel,
   output logic [N*N*P-1:0]    o_dequeue,
   output logic                o_err
);

   typedef enum logic {S_IDLE = 1'b0, S_XFER = 1'b1} state_e;

   state_e              state_q [N];
   state_e              state_d [N];
   logic [3:0]          cnt_q   [N];
   logic [3:0]          cnt_d   [N];
   logic [LOGN-1:0]     dst_q   [N];
   logic [LOGN-1:0]     dst_d   [N];
   logic [N-1:0]        in_idle_q, in_idle_d;
   logic [N-1:0]        out_idle_q, out_idle_d;
   logic [N-1:0]        xv_q, xv_d;
   logic [N*LOGN-1:0]   sel_q, sel_d;
   logic [N*N*P-1:0]    deq_q, deq_d;
   logic [N-1:0]        claimed;

   always_comb begin
      logic [N-1:0] row;
      logic [P-1:0] voq;
      int           top;
      row        = '0;
      voq        = '0;
      top        = 0;
      in_idle_d  = in_idle_q;
      out_idle_d = out_idle_q;
      xv_d       = xv_q;
      sel_d      = sel_q;
      deq_d      = '0;
      claimed    = '0;
      for (int i = 0; i < N; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         dst_d[i]   = dst_q[i];
      end
      // Inputs are visited in ascending order, so 'claimed' makes the lowest
      // eligible input win an output that several inputs target at once.
      for (int i = 0; i < N; i++) begin
         row = i_acc_grant[i*N +: N];
         if (state_q[i] == S_XFER) begin
            if (cnt_q[i] == 4'd0) begin
               state_d[i]   = S_IDLE;
               in_idle_d[i] = 1'b1;
               for (int j = 0; j < N; j++) begin
                  if (dst_q[i] == LOGN'(j)) begin
                     out_idle_d[j] = 1'b1;
                     xv_d[j]       = 1'b0;
                  end
               end
            end else begin
               cnt_d[i] = cnt_q[i] - 4'd1;
            end
         end else if (in_idle_q[i] && $onehot(row)) begin
            for (int j = 0; j < N; j++) begin
               voq = i_priority[(i*N+j)*P +: P];
               if (row[j] && out_idle_q[j] && !claimed[j] && (|voq)) begin
                  claimed[j]    = 1'b1;
                  state_d[i]    = S_XFER;
                  cnt_d[i]      = 4'(CELL_LEN - 1);
                  dst_d[i]      = LOGN'(j);
                  in_idle_d[i]  = 1'b0;
                  out_idle_d[j] = 1'b0;
                  xv_d[j]       = 1'b1;
                  sel_d[j*LOGN +: LOGN] = LOGN'(i);
                  // Highest occupied class wins (class P-1 is highest).
                  top = 0;
                  for (int p = 0; p < P; p++) begin
                     if (voq[p]) top = p;
                  end
                  for (int p = 0; p < P; p++) begin
                     if (p == top) deq_d[(i*N+j)*P + p] = 1'b1;
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N; i++) begin
            state_q[i] <= S_IDLE;
            cnt_q[i]   <= '0;
            dst_q[i]   <= '0;
         end
         in_idle_q  <= '1;
         out_idle_q <= '1;
         xv_q       <= '0;
         sel_q      <= '0;
         deq_q      <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
            dst_q[i]   <= dst_d[i];
         end
         in_idle_q  <= in_idle_d;
         out_idle_q <= out_idle_d;
         xv_q       <= xv_d;
         sel_q      <= sel_d;
         deq_q      <= deq_d;
      end
   end

   assign o_input_idle  = in_idle_q;
   assign o_output_idle = out_idle_q;
   assign o_xbar_valid  = xv_q;
   assign o_xbar_sel    = sel_q;
   assign o_dequeue     = deq_q;

`ifdef GRANT_CHECK_EN
   logic err_q, err_d;

   // Flags any grant the executor has to ignore: busy port, multi-bit row,
   // column collision or empty VOQ.
   always_comb begin
      logic [N-1:0] row_e;
      logic [N-1:0] col_seen;
      row_e    = '0;
      col_seen = '0;
      err_d    = err_q;
      for (int i = 0; i < N; i++) begin
         row_e = i_acc_grant[i*N +: N];
         if ((|row_e) && !$onehot(row_e)) err_d = 1'b1;
         for (int j = 0; j < N; j++) begin
            if (row_e[j]) begin
               if (!in_idle_q[i] || !out_idle_q[j] ||
                   !(|i_priority[(i*N+j)*P +: P])) err_d = 1'b1;
               if (col_seen[j]) err_d = 1'b1;
               col_seen[j] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) err_q <= 1'b0;
      else        err_q <= err_d;
   end

   assign o_err = err_q;
`else
   assign o_err = 1'b0;
`endif

endmodule
